// File: rtl/seq_frame_pkg.sv
// Shared definitions for the 11010 sync-word serial link.
// Contents:
//   state_e      - transmitter FSM state encoding (3-bit; codes 101..111 unused)
//   DEF_SYNC_LEN - default sync pattern length, shared with the receive-side detector
//   DEF_SYNC_PAT - default sync pattern, sent MSB-first
//   max()        - integer maximum, used for counter sizing
package seq_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_SYNC   = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_GAP    = 3'b100
  } state_e;

  localparam int unsigned                 DEF_SYNC_LEN = 5;
  localparam logic [DEF_SYNC_LEN-1:0]     DEF_SYNC_PAT = 5'b11010;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-in / serial-out payload register for seq_frame_tx.
// Loads a W-bit word, shifts left one bit per enabled cycle, and exposes the
// current MSB. With PAR_EN set it also accumulates the XOR of every bit shifted
// out, so after W shifts parity_o is the even parity of the loaded word.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset, clears all state
//   load_i   - load data_i (has priority over shift_i)
//   shift_i  - shift left by one, zero fill
//   data_i   - parallel payload word
//   msb_o    - current MSB (next serial bit)
//   parity_o - running XOR of bits shifted out (0 when PAR_EN is clear)
module seq_piso_shreg #(
  parameter int unsigned W      = 8,
  parameter bit          PAR_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o,
  output logic         parity_o
);

  logic [W-1:0] sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= data_i;
    end else if (shift_i) begin
      sh_q <= sh_q << 1;
    end
  end

  assign msb_o = sh_q[W-1];

  if (PAR_EN) begin : g_par
    logic par_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        par_q <= 1'b0;
      end else if (load_i) begin
        par_q <= 1'b0;
      end else if (shift_i) begin
        par_q <= par_q ^ sh_q[W-1];
      end
    end

    assign parity_o = par_q;
  end else begin : g_nopar
    assign parity_o = 1'b0;
  end

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter for the 11010 sync-word link.
// Accepts a payload word on a valid/ready handshake and sends, one bit per
// clock and MSB-first: SYNC_PAT, the payload, an optional even-parity bit,
// then IDLE_GAP forced-zero cycles so the downstream detector returns to its
// start state.
// Optional feature: define SEQ_FRAME_TX_PARITY_EN to append the parity bit.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   in_valid - payload offered
//   in_data  - payload word, sampled on the handshake edge
//   in_ready - transmitter can accept a payload (IDLE and not in reset)
//   outp     - serial bit (0 whenever out_en is 0)
//   out_en   - outp carries a frame bit this cycle
//   busy     - frame or gap in progress
//   state    - current FSM state, for debug
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          SYNC_LEN = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0]  SYNC_PAT = DEF_SYNC_PAT,
  parameter int unsigned          IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              outp,
  output logic              out_en,
  output logic              busy,
  output logic [2:0]        state
);

  localparam int unsigned CW = $clog2(max(max(SYNC_LEN, DATA_W), max(IDLE_GAP, 1))) + 1;

  localparam logic [CW-1:0] SYNC_RLD = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] DATA_RLD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_RLD  = (IDLE_GAP > 0) ? CW'(IDLE_GAP - 1) : '0;
  localparam state_e        POST_ST  = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            outp_q, outp_d;
  logic            out_en_q, out_en_d;
  logic            busy_q, busy_d;
  logic            hs;
  logic            msb_w;
  logic            par_w;
  logic            sync_bit;

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign hs       = in_valid && in_ready;

  seq_piso_shreg #(
    .W      (DATA_W),
    .PAR_EN (PAR_EN)
  ) u_shreg (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (hs),
    .shift_i  (state_d == ST_DATA),
    .data_i   (in_data),
    .msb_o    (msb_w),
    .parity_o (par_w)
  );

  // State register; outputs are registered from the next-state values so the
  // first sync bit is on outp in the cycle right after the handshake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      outp_q   <= 1'b0;
      out_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      outp_q   <= outp_d;
      out_en_q <= out_en_d;
      busy_q   <= busy_d;
    end
  end

  // Next state; the counter reloads on every state entry and counts down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d = ST_SYNC;
          cnt_d   = SYNC_RLD;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = DATA_RLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_d = ST_PARITY;
          cnt_d   = '0;
`else
          state_d = POST_ST;
          cnt_d   = GAP_RLD;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      ST_PARITY: begin
        state_d = POST_ST;
        cnt_d   = GAP_RLD;
      end
`endif
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sync bit i is SYNC_PAT[SYNC_LEN-1-i], which equals SYNC_PAT[cnt] while counting down.
  always_comb begin
    sync_bit = 1'b0;
    for (int unsigned i = 0; i < SYNC_LEN; i++) begin
      if (cnt_d == CW'(i)) sync_bit = SYNC_PAT[i];
    end
  end

  // Output decode from the next state. ST_PARITY is unreachable when the
  // parity feature is off, and par_w is then constant 0.
  always_comb begin
    outp_d   = 1'b0;
    out_en_d = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_SYNC: begin
        outp_d   = sync_bit;
        out_en_d = 1'b1;
      end
      ST_DATA: begin
        outp_d   = msb_w;
        out_en_d = 1'b1;
      end
      ST_PARITY: begin
        outp_d   = par_w;
        out_en_d = 1'b1;
      end
      default: begin
        outp_d   = 1'b0;
        out_en_d = 1'b0;
      end
    endcase
  end

  assign outp   = outp_q;
  assign out_en = out_en_q;
  assign busy   = busy_q;
  assign state  = state_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
module tb_seq_frame_tx;

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int FB = 14;
`else
  localparam int FB = 13;
`endif
  localparam int GAP = 2;
  localparam int PER = FB + GAP + 1;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       outp;
  logic       out_en;
  logic       busy;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  logic       r_outp  [0:63];
  logic       r_en    [0:63];
  logic       r_busy  [0:63];
  logic       r_rdy   [0:63];
  logic       r_det   [0:63];
  logic [2:0] r_state [0:63];

  // Reference Moore 11010 detector fed from the serial line.
  logic [4:0] hist;
  logic       det;

  seq_frame_tx #(
    .DATA_W   (8),
    .SYNC_LEN (5),
    .SYNC_PAT (5'b11010),
    .IDLE_GAP (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .outp     (outp),
    .out_en   (out_en),
    .busy     (busy),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) hist <= '0;
    else     hist <= {hist[3:0], outp};
  end
  assign det = (hist == 5'b11010);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Sample n cycles on the falling edge; after the first sample apply nd and
  // optionally drop in_valid.
  task automatic record(input int n, input bit hold, input logic [7:0] nd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r_outp[i]  = outp;
      r_en[i]    = out_en;
      r_busy[i]  = busy;
      r_rdy[i]   = in_ready;
      r_det[i]   = det;
      r_state[i] = state;
      if (i == 0) begin
        in_data = nd;
        if (!hold) in_valid = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input int base, input logic [12:0] bits, input logic par,
                             input string tag);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("%s_en%0d", tag, i), r_en[base+i], 1);
      check($sformatf("%s_bit%0d", tag, i), r_outp[base+i], bits[12-i]);
    end
`ifdef SEQ_FRAME_TX_PARITY_EN
    check($sformatf("%s_par_en", tag), r_en[base+13], 1);
    check($sformatf("%s_par", tag), r_outp[base+13], par);
`else
    check($sformatf("%s_par_unused", tag), {31'd0, par}, 0);
`endif
    for (int g = 0; g < GAP; g++) begin
      check($sformatf("%s_gap_en%0d", tag, g), r_en[base+FB+g], 0);
      check($sformatf("%s_gap_outp%0d", tag, g), r_outp[base+FB+g], 0);
      check($sformatf("%s_gap_busy%0d", tag, g), r_busy[base+FB+g], 1);
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    check({tag, "_idle_state"}, r_state[idx], 3'b000);
    check({tag, "_idle_busy"}, r_busy[idx], 0);
    check({tag, "_idle_rdy"}, r_rdy[idx], 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int cnt_a;
    int cnt_b;

    // 1: reset held with a payload offered; nothing may be accepted
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_state", state, 3'b000);
      check("rst_outp", outp, 0);
      check("rst_en", out_en, 0);
      check("rst_busy", busy, 0);
      check("rst_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("post_rst_rdy", in_ready, 1);
    @(negedge clk);
    check("post_rst_state", state, 3'b000);

    // 2: single A5 frame; in_data changes after the handshake
    in_valid = 1'b1;
    in_data  = 8'hA5;
    record(PER, 1'b0, 8'h5A);
    check_frame(0, 13'b11010_10100101, 1'b0, "a5");
    check_idle(PER - 1, "a5");

    // 3: back-to-back FF then 00 with in_valid held
    in_valid = 1'b1;
    in_data  = 8'hFF;
    record(2 * PER, 1'b1, 8'h00);
    in_valid = 1'b0;
    check_frame(0, 13'b11010_11111111, 1'b0, "ff");
    check("b2b_pre_en", r_en[PER-1], 0);
    check("b2b_pre_rdy", r_rdy[PER-1], 1);
    check_frame(PER, 13'b11010_00000000, 1'b0, "b2b00");
    viol = 0;
    for (int i = 0; i < 2 * PER; i++) if (r_busy[i] && r_rdy[i]) viol++;
    check("b2b_rdy_while_busy", viol, 0);

    // 6: loopback into the detector, two 00 frames
    in_valid = 1'b1;
    in_data  = 8'h00;
    record(2 * PER, 1'b1, 8'h00);
    in_valid = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < PER; i++) begin
      if (r_det[i]) cnt_a++;
      if (r_det[PER+i]) cnt_b++;
    end
    check("det_count_f1", cnt_a, 1);
    check("det_count_f2", cnt_b, 1);
    check("det_pos_f1", r_det[5], 1);
    check("det_pos_f2", r_det[PER+5], 1);

    // 4: abort during the 3rd data bit, then a clean 3C frame
    in_valid = 1'b1;
    in_data  = 8'hA5;
    record(8, 1'b0, 8'hA5);
    check("abort_d3_state", r_state[7], 3'b010);
    check("abort_d3_en", r_en[7], 1);
    check("abort_d3_bit", r_outp[7], 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", state, 3'b000);
    check("abort_en", out_en, 0);
    check("abort_outp", outp, 0);
    check("abort_busy", busy, 0);
    check("abort_rdy", in_ready, 0);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    record(PER, 1'b0, 8'hFF);
    check_frame(0, 13'b11010_00111100, 1'b0, "3c");
    check_idle(PER - 1, "3c");

`ifdef SEQ_FRAME_TX_PARITY_EN
    // 5: parity bit
    in_valid = 1'b1;
    in_data  = 8'h07;
    record(PER, 1'b0, 8'h00);
    check_frame(0, 13'b11010_00000111, 1'b1, "p07");
    in_valid = 1'b1;
    in_data  = 8'h03;
    record(PER, 1'b0, 8'h00);
    check_frame(0, 13'b11010_00000011, 1'b0, "p03");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
